// File: rtl/vga_sync_gen.sv
// VGA timing generator: column/row counters, active-region flags, connector syncs,
// end-of-frame pulse and a game tick every FRAMES_PER_TICK enabled frames.
module vga_sync_gen #(
  parameter int unsigned TOTAL_COLS      = 800,
  parameter int unsigned TOTAL_ROWS      = 525,
  parameter int unsigned ACTIVE_COLS     = 640,
  parameter int unsigned ACTIVE_ROWS     = 480,
  parameter int unsigned FRONT_PORCH_H   = 16,
  parameter int unsigned SYNC_H          = 96,
  parameter int unsigned BACK_PORCH_H    = 48,
  parameter int unsigned FRONT_PORCH_V   = 10,
  parameter int unsigned SYNC_V          = 2,
  parameter int unsigned BACK_PORCH_V    = 33,
  parameter int unsigned FRAMES_PER_TICK = 30
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_Tick_En,
  input  logic       i_Tick_Clr,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_VGA_HSync,
  output logic       o_VGA_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_End,
  output logic       o_Game_Tick
);

  localparam int unsigned CW           = 10;
  localparam int unsigned FW           = 6;
  localparam int unsigned H_SYNC_START = ACTIVE_COLS + FRONT_PORCH_H;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + SYNC_H;
  localparam int unsigned V_SYNC_START = ACTIVE_ROWS + FRONT_PORCH_V;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + SYNC_V;

  // Elaboration-time sanity checks on the timing parameters
  if (ACTIVE_COLS + FRONT_PORCH_H + SYNC_H + BACK_PORCH_H != TOTAL_COLS) begin : g_bad_h
    $error("vga_sync_gen: horizontal timing does not sum to TOTAL_COLS");
  end
  if (ACTIVE_ROWS + FRONT_PORCH_V + SYNC_V + BACK_PORCH_V != TOTAL_ROWS) begin : g_bad_v
    $error("vga_sync_gen: vertical timing does not sum to TOTAL_ROWS");
  end
  if (FRAMES_PER_TICK < 1 || FRAMES_PER_TICK > 63) begin : g_bad_fpt
    $error("vga_sync_gen: FRAMES_PER_TICK must be 1..63");
  end

  logic [CW-1:0] col_nxt;
  logic [CW-1:0] row_nxt;
  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] frame_cnt_nxt;
  logic          tick_nxt;

  // Next pixel position; all outputs are decoded from it so they align with the counts
  always_comb begin
    col_nxt = o_Col_Count + CW'(1);
    row_nxt = o_Row_Count;
    if (o_Col_Count == CW'(TOTAL_COLS - 1)) begin
      col_nxt = '0;
      if (o_Row_Count == CW'(TOTAL_ROWS - 1)) begin
        row_nxt = '0;
      end else begin
        row_nxt = o_Row_Count + CW'(1);
      end
    end
  end

  // Frame counter: clear beats increment; the tick lands on the first pixel of the next frame
  always_comb begin
    frame_cnt_nxt = frame_cnt;
    tick_nxt      = 1'b0;
    if (i_Tick_Clr) begin
      frame_cnt_nxt = '0;
    end else if (o_Frame_End && i_Tick_En) begin
      if (frame_cnt == FW'(FRAMES_PER_TICK - 1)) begin
        frame_cnt_nxt = '0;
        tick_nxt      = 1'b1;
      end else begin
        frame_cnt_nxt = frame_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_Col_Count <= '0;
      o_Row_Count <= '0;
      frame_cnt   <= '0;
      o_HSync     <= 1'b1;
      o_VSync     <= 1'b1;
      o_VGA_HSync <= 1'b1;
      o_VGA_VSync <= 1'b1;
      o_Frame_End <= 1'b0;
      o_Game_Tick <= 1'b0;
    end else begin
      o_Col_Count <= col_nxt;
      o_Row_Count <= row_nxt;
      frame_cnt   <= frame_cnt_nxt;
      o_HSync     <= (col_nxt < CW'(ACTIVE_COLS));
      o_VSync     <= (row_nxt < CW'(ACTIVE_ROWS));
      o_VGA_HSync <= !((col_nxt >= CW'(H_SYNC_START)) && (col_nxt < CW'(H_SYNC_END)));
      o_VGA_VSync <= !((row_nxt >= CW'(V_SYNC_START)) && (row_nxt < CW'(V_SYNC_END)));
      o_Frame_End <= (col_nxt == CW'(TOTAL_COLS - 1)) && (row_nxt == CW'(TOTAL_ROWS - 1));
      o_Game_Tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default-timing instance for line checks and
// a shrunken-timing instance (20x10, two frames per tick) for frame, tick and reset checks.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst_a_n, en_a, clr_a;
  logic       rst_b_n, en_b, clr_b;
  logic       a_hs, a_vs, a_vhs, a_vvs, a_fe, a_gt;
  logic       b_hs, b_vs, b_vhs, b_vvs, b_fe, b_gt;
  logic [9:0] a_col, a_row, b_col, b_row;
  logic [25:0] obs_a, obs_b, exp_v;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         eb      = 0;

  always #5 clk = ~clk;

  assign obs_a = {a_col, a_row, a_hs, a_vs, a_vhs, a_vvs, a_fe, a_gt};
  assign obs_b = {b_col, b_row, b_hs, b_vs, b_vhs, b_vvs, b_fe, b_gt};

  vga_sync_gen u_dut_a (
    .i_Clk(clk), .i_Reset_n(rst_a_n), .i_Tick_En(en_a), .i_Tick_Clr(clr_a),
    .o_HSync(a_hs), .o_VSync(a_vs), .o_VGA_HSync(a_vhs), .o_VGA_VSync(a_vvs),
    .o_Col_Count(a_col), .o_Row_Count(a_row), .o_Frame_End(a_fe), .o_Game_Tick(a_gt)
  );

  vga_sync_gen #(
    .TOTAL_COLS(20), .TOTAL_ROWS(10), .ACTIVE_COLS(12), .ACTIVE_ROWS(6),
    .FRONT_PORCH_H(2), .SYNC_H(3), .BACK_PORCH_H(3),
    .FRONT_PORCH_V(1), .SYNC_V(2), .BACK_PORCH_V(1),
    .FRAMES_PER_TICK(2)
  ) u_dut_b (
    .i_Clk(clk), .i_Reset_n(rst_b_n), .i_Tick_En(en_b), .i_Tick_Clr(clr_b),
    .o_HSync(b_hs), .o_VSync(b_vs), .o_VGA_HSync(b_vhs), .o_VGA_VSync(b_vvs),
    .o_Col_Count(b_col), .o_Row_Count(b_row), .o_Frame_End(b_fe), .o_Game_Tick(b_gt)
  );

  // Expected output vector {col,row,hs,vs,vga_hs,vga_vs,frame_end,tick} from a pixel position
  function automatic logic [25:0] model(input int col, input int row, input int ac, input int ar,
                                        input int hss, input int hse, input int vss, input int vse,
                                        input logic fe, input logic gt);
    model = {10'(col), 10'(row), col < ac, row < ar,
             !(col >= hss && col < hse), !(row >= vss && row < vse), fe, gt};
  endfunction

  function automatic logic [25:0] model_b(input int e, input logic gt);
    model_b = model(e % 20, (e / 20) % 10, 12, 6, 14, 17, 7, 9, (e % 200) == 199, gt);
  endfunction

  task automatic test_reset();
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    en_a = 1'b1; clr_a = 1'b0; en_b = 1'b1; clr_b = 1'b0;
    repeat (3) @(negedge clk);
    exp_v = model(0, 0, 640, 480, 656, 752, 490, 492, 1'b0, 1'b0);
    n_tests++;
    if (obs_a !== exp_v) begin
      n_fail++; $display("FAIL reset_a: got %h expected %h", obs_a, exp_v);
    end
    exp_v = model_b(0, 1'b0);
    n_tests++;
    if (obs_b !== exp_v) begin
      n_fail++; $display("FAIL reset_b: got %h expected %h", obs_b, exp_v);
    end
  endtask

  task automatic test_line();
    int lows = 0;
    logic [19:0] want;
    rst_a_n = 1'b1;
    for (int e = 1; e <= 800; e++) begin
      @(negedge clk);
      exp_v = model(e % 800, e / 800, 640, 480, 656, 752, 490, 492, 1'b0, 1'b0);
      n_tests++;
      if (obs_a !== exp_v) begin
        n_fail++; $display("FAIL line e=%0d: got %h expected %h", e, obs_a, exp_v);
      end
      if (!a_vhs) lows++;
    end
    n_tests++;
    if (lows != 96) begin
      n_fail++; $display("FAIL hsync_low_len: got %0d expected 96", lows);
    end
    want = {10'd0, 10'd1};
    n_tests++;
    if ({a_col, a_row} !== want) begin
      n_fail++; $display("FAIL line_wrap: got (%0d,%0d) expected (0,1)", a_col, a_row);
    end
  endtask

  task automatic test_frame();
    int lows = 0;
    int fes  = 0;
    rst_b_n = 1'b1;
    eb = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      eb++;
      exp_v = model_b(eb, 1'b0);
      n_tests++;
      if (obs_b !== exp_v) begin
        n_fail++; $display("FAIL frame e=%0d: got %h expected %h", eb, obs_b, exp_v);
      end
      if (!b_vvs) lows++;
      if (b_fe) fes++;
    end
    n_tests++;
    if (lows != 40) begin
      n_fail++; $display("FAIL vsync_low_len: got %0d expected 40", lows);
    end
    n_tests++;
    if (fes != 1) begin
      n_fail++; $display("FAIL frame_end_count: got %0d expected 1", fes);
    end
  endtask

  task automatic test_game_tick();
    int ticks = 0;
    while (eb < 1200) begin
      en_b = ((eb / 200) + 1) != 3;
      @(negedge clk);
      eb++;
      exp_v = model_b(eb, (eb == 400) || (eb == 1000));
      n_tests++;
      if (obs_b !== exp_v) begin
        n_fail++; $display("FAIL tick e=%0d: got %h expected %h", eb, obs_b, exp_v);
      end
      if (b_gt) ticks++;
    end
    en_b = 1'b1;
    n_tests++;
    if (ticks != 2) begin
      n_fail++; $display("FAIL tick_count: got %0d expected 2", ticks);
    end
  endtask

  task automatic test_tick_clr();
    int ticks = 0;
    while (eb < 1801) begin
      clr_b = (eb == 1399);
      @(negedge clk);
      eb++;
      exp_v = model_b(eb, eb == 1800);
      n_tests++;
      if (obs_b !== exp_v) begin
        n_fail++; $display("FAIL clr e=%0d: got %h expected %h", eb, obs_b, exp_v);
      end
      if (b_gt) ticks++;
    end
    clr_b = 1'b0;
    n_tests++;
    if (ticks != 1) begin
      n_fail++; $display("FAIL clr_tick_count: got %0d expected 1", ticks);
    end
  endtask

  task automatic test_reset_mid_frame();
    int first_fe = -1;
    while (eb < 2110) begin
      @(negedge clk);
      eb++;
      exp_v = model_b(eb, 1'b0);
      n_tests++;
      if (obs_b !== exp_v) begin
        n_fail++; $display("FAIL pre_rst e=%0d: got %h expected %h", eb, obs_b, exp_v);
      end
    end
    // Mid-cycle assertion at (10,5) with a frame already counted toward the next tick
    #2 rst_b_n = 1'b0;
    #1;
    exp_v = model_b(0, 1'b0);
    n_tests++;
    if (obs_b !== exp_v) begin
      n_fail++; $display("FAIL async_rst: got %h expected %h", obs_b, exp_v);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (obs_b !== exp_v) begin
      n_fail++; $display("FAIL rst_hold: got %h expected %h", obs_b, exp_v);
    end
    rst_b_n = 1'b1;
    eb = 0;
    for (int i = 0; i < 401; i++) begin
      @(negedge clk);
      eb++;
      exp_v = model_b(eb, eb == 400);
      n_tests++;
      if (obs_b !== exp_v) begin
        n_fail++; $display("FAIL post_rst e=%0d: got %h expected %h", eb, obs_b, exp_v);
      end
      if (b_fe && first_fe < 0) first_fe = eb;
    end
    n_tests++;
    if (first_fe != 199) begin
      n_fail++; $display("FAIL first_frame_end: got %0d expected 199", first_fe);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_game_tick();
    test_tick_clr();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
